// File: rtl/ps2_device_port_if.sv
// Byte-level bus of the PS/2 device endpoint.
//
// Handshake: tx_load is a one-cycle strobe that the device accepts only in a
// cycle where tx_busy=0; tx_data is captured in that same cycle and tx_busy
// rises on the next cycle. A strobe while tx_busy=1 is dropped. tx_busy stays
// high until the frame ends with exactly one tx_done or tx_abort pulse.
// rx_valid and rx_error are one-cycle pulses with no back-pressure. rx_data
// changes only in the cycle that rx_valid pulses.
interface ps2_device_port_if;
   logic [7:0] tx_data;
   logic       tx_load;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_abort;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_error;
   logic [1:0] state_dbg;

   modport master (
      output tx_data, tx_load,
      input  tx_busy, tx_done, tx_abort, rx_data, rx_valid, rx_error, state_dbg
   );

   modport slave (
      input  tx_data, tx_load,
      output tx_busy, tx_done, tx_abort, rx_data, rx_valid, rx_error, state_dbg
   );
endinterface

// File: rtl/ps2_device_port.sv
// Device-side PS/2 endpoint. The device generates the PS/2 clock, sends
// device->host bytes, and receives host->device commands, including the ack
// bit. Both lines are open drain: they are driven 0 or released to Z.
module ps2_device_port #(
   parameter int HALF     = 1120,
   parameter int IDLE_MIN = 1400,
   parameter int GAP      = 2240
) (
   input  logic clk,
   input  logic rst_n,
   inout  wire  ps2clk_ext,
   inout  wire  ps2data_ext,
   ps2_device_port_if.slave bus
);

   localparam int PH_W = $clog2(2 * HALF);
   localparam int IC_W = $clog2(IDLE_MIN + 1);
   localparam int GC_W = $clog2(GAP);

   localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * HALF - 1);
   localparam logic [PH_W-1:0] PH_HALF = PH_W'(HALF);
   localparam logic [PH_W-1:0] PH_CHK  = PH_W'(HALF - 1);
   localparam logic [PH_W-1:0] PH_SAMP = PH_W'(HALF / 2);
   localparam logic [IC_W-1:0] IC_MIN  = IC_W'(IDLE_MIN);
   localparam logic [GC_W-1:0] GC_LAST = GC_W'(GAP - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TXBIT = 2'd1,
      RXBIT = 2'd2,
      GAPW  = 2'd3
   } state_t;

   logic            sclk_m, sclk, sdat_m, sdat;
   state_t          state_q, state_n;
   logic [PH_W-1:0] ph_q, ph_n;
   logic [3:0]      bit_q, bit_n;
   logic [IC_W-1:0] idle_q, idle_n;
   logic [GC_W-1:0] gap_q, gap_n;
   logic [9:0]      rx_shift_q, rx_shift_n;
   logic            pending_q;
   logic [7:0]      tx_byte_q;
   logic [7:0]      rx_data_q;
   logic            clk_low_q, dat_low_q, clk_low_n, dat_low_n;
   logic            tx_done_q, tx_abort_q, rx_valid_q, rx_error_q;
   logic            tx_done_n, tx_abort_n, rx_valid_n, rx_error_n;
   logic            pend_clr, rx_load, inhibit, ph_wrap;
   logic [15:0]     tx_frame;

   // Frame bits 0..10: start, D0..D7, odd parity, stop; padded with ones.
   assign tx_frame = {5'h1f, 1'b1, ~^tx_byte_q, tx_byte_q, 1'b0};

   // Open-drain line drivers.
   assign ps2clk_ext  = clk_low_q ? 1'b0 : 1'bz;
   assign ps2data_ext = dat_low_q ? 1'b0 : 1'bz;

   assign bus.tx_busy   = pending_q;
   assign bus.tx_done   = tx_done_q;
   assign bus.tx_abort  = tx_abort_q;
   assign bus.rx_data   = rx_data_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.rx_error  = rx_error_q;
   assign bus.state_dbg = state_q;

   // Two-flop synchronisers; released lines read as 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_m <= 1'b1;
         sclk   <= 1'b1;
         sdat_m <= 1'b1;
         sdat   <= 1'b1;
      end else begin
         sclk_m <= ps2clk_ext;
         sclk   <= sclk_m;
         sdat_m <= ps2data_ext;
         sdat   <= sdat_m;
      end
   end

   // FSM and frame-position registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ph_q       <= '0;
         bit_q      <= '0;
         idle_q     <= '0;
         gap_q      <= '0;
         rx_shift_q <= '0;
      end else begin
         state_q    <= state_n;
         ph_q       <= ph_n;
         bit_q      <= bit_n;
         idle_q     <= idle_n;
         gap_q      <= gap_n;
         rx_shift_q <= rx_shift_n;
      end
   end

   // Next state, line drive and status pulses. The line drivers are
   // registered from next-state values, so the drive follows the state register.
   always_comb begin
      state_n    = state_q;
      ph_n       = ph_q;
      bit_n      = bit_q;
      idle_n     = '0;
      gap_n      = '0;
      rx_shift_n = rx_shift_q;
      pend_clr   = 1'b0;
      rx_load    = 1'b0;
      tx_done_n  = 1'b0;
      tx_abort_n = 1'b0;
      rx_valid_n = 1'b0;
      rx_error_n = 1'b0;
      // The host pulls the clock low while the device has released it.
      inhibit    = (bit_q != 4'd0) && (ph_q == PH_CHK) && !sclk;
      ph_wrap    = (ph_q == PH_LAST);
      case (state_q)
         IDLE: begin
            if (sclk && sdat) begin
               idle_n = (idle_q >= IC_MIN) ? idle_q : idle_q + 1'b1;
            end
            if (sclk && !sdat) begin
               state_n    = RXBIT;
               ph_n       = '0;
               bit_n      = '0;
               rx_shift_n = '0;
            end else if (pending_q && (idle_q >= IC_MIN)) begin
               state_n = TXBIT;
               ph_n    = '0;
               bit_n   = '0;
            end
         end
         TXBIT: begin
            if (inhibit) begin
               tx_abort_n = 1'b1;
               pend_clr   = 1'b1;
               state_n    = GAPW;
            end else if (ph_wrap) begin
               if (bit_q == 4'd10) begin
                  tx_done_n = 1'b1;
                  pend_clr  = 1'b1;
                  state_n   = GAPW;
               end else begin
                  ph_n  = '0;
                  bit_n = bit_q + 4'd1;
               end
            end else begin
               ph_n = ph_q + 1'b1;
            end
         end
         RXBIT: begin
            if (ph_q == PH_SAMP) begin
               for (int i = 0; i < 10; i++) begin
                  if (bit_q == 4'(i)) rx_shift_n[i] = sdat;
               end
            end
            if (inhibit) begin
               rx_error_n = 1'b1;
               state_n    = GAPW;
            end else if (ph_wrap) begin
               if (bit_q == 4'd10) begin
                  if ((^rx_shift_q[8:0]) && rx_shift_q[9]) begin
                     rx_valid_n = 1'b1;
                     rx_load    = 1'b1;
                  end else begin
                     rx_error_n = 1'b1;
                  end
                  state_n = GAPW;
               end else begin
                  ph_n  = '0;
                  bit_n = bit_q + 4'd1;
               end
            end else begin
               ph_n = ph_q + 1'b1;
            end
         end
         GAPW: begin
            if (gap_q == GC_LAST) begin
               state_n = IDLE;
            end else begin
               gap_n = gap_q + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
      clk_low_n = ((state_n == TXBIT) || (state_n == RXBIT)) && (ph_n >= PH_HALF);
      // TX: a 0 bit pulls data low. RX: ack on clock 10 only when stop was 1.
      dat_low_n = ((state_n == TXBIT) && !tx_frame[bit_n]) ||
                  ((state_n == RXBIT) && (bit_n == 4'd10) && rx_shift_n[9]);
   end

   // Pending byte, received byte, line drivers and pulse outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q  <= 1'b0;
         tx_byte_q  <= '0;
         rx_data_q  <= '0;
         clk_low_q  <= 1'b0;
         dat_low_q  <= 1'b0;
         tx_done_q  <= 1'b0;
         tx_abort_q <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_error_q <= 1'b0;
      end else begin
         if (pend_clr) begin
            pending_q <= 1'b0;
         end else if (bus.tx_load && !pending_q) begin
            pending_q <= 1'b1;
            tx_byte_q <= bus.tx_data;
         end
         if (rx_load) rx_data_q <= rx_shift_q[7:0];
         clk_low_q  <= clk_low_n;
         dat_low_q  <= dat_low_n;
         tx_done_q  <= tx_done_n;
         tx_abort_q <= tx_abort_n;
         rx_valid_q <= rx_valid_n;
         rx_error_q <= rx_error_n;
      end
   end

endmodule

// File: tb/tb_ps2_device_port.sv
// Directed bench for ps2_device_port: a host model on pulled-up open-drain
// lines, device frames checked bit by bit against hand-computed frames.
module tb_ps2_device_port;

   localparam int HALF_T = 20;
   localparam int IDLE_T = 30;
   localparam int GAP_T  = 50;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic host_clk_low = 1'b0;
   logic host_dat_low = 1'b0;
   wire  ps2clk_w;
   wire  ps2data_w;
   pullup (ps2clk_w);
   pullup (ps2data_w);
   assign ps2clk_w  = host_clk_low ? 1'b0 : 1'bz;
   assign ps2data_w = host_dat_low ? 1'b0 : 1'bz;

   ps2_device_port_if bus_if ();

   ps2_device_port #(.HALF(HALF_T), .IDLE_MIN(IDLE_T), .GAP(GAP_T)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ps2clk_ext  (ps2clk_w),
      .ps2data_ext (ps2data_w),
      .bus         (bus_if.slave)
   );

   // ---------------- scoreboard ----------------
   int         n_checks = 0;
   int         n_errors = 0;
   int         done_cnt = 0;
   int         abort_cnt = 0;
   int         overlap_cnt = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (bus_if.tx_done) done_cnt++;
      if (bus_if.tx_abort) abort_cnt++;
      if ((bus_if.tx_done || bus_if.tx_abort) && (bus_if.rx_valid || bus_if.rx_error))
         overlap_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load_byte(input logic [7:0] b);
      bus_if.tx_data = b;
      bus_if.tx_load = 1'b1;
      @(negedge clk);
      bus_if.tx_load = 1'b0;
   endtask

   task automatic wait_fall(output bit ok, output int n);
      logic p;
      ok = 1'b0;
      n  = 0;
      p  = ps2clk_w;
      for (int i = 0; i < 4 * HALF_T; i++) begin
         @(negedge clk);
         n++;
         if (p === 1'b1 && ps2clk_w === 1'b0) begin
            ok = 1'b1;
            break;
         end
         p = ps2clk_w;
      end
   endtask

   task automatic wait_start(output bit ok, output int n);
      ok = 1'b0;
      n  = 0;
      for (int i = 0; i < GAP_T + IDLE_T + 4 * HALF_T; i++) begin
         @(negedge clk);
         n++;
         if (ps2data_w === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Collects a device frame; frame[i] is the data level at clock fall i.
   task automatic recv_tx(input logic [10:0] frame, output int first_n);
      bit ok;
      int n;
      bit seen;
      first_n = 0;
      exp_q.delete();
      for (int i = 0; i < 11; i++) exp_q.push_back({7'd0, frame[i]});
      for (int i = 0; i < 11; i++) begin
         wait_fall(ok, n);
         if (i == 0) first_n = n;
         check("tx_fall", {31'd0, ok}, 32'd1);
         if (!ok) begin
            exp_q.delete();
            return;
         end
         check("tx_bit", {31'd0, ps2data_w}, {24'd0, exp_q.pop_front()});
      end
      seen = 1'b0;
      for (int j = 0; j < 4 * HALF_T; j++) begin
         @(negedge clk);
         if (bus_if.tx_done) begin
            seen = 1'b1;
            break;
         end
      end
      check("tx_done", {31'd0, seen}, 32'd1);
      check("tx_busy_clr", {31'd0, bus_if.tx_busy}, 32'd0);
   endtask

   // Host request-to-send followed by a 10-bit host frame {stop, parity, data}.
   task automatic host_send(input logic [7:0] d, input logic par, input logic stop,
                            input bit do_load, input logic [7:0] ld,
                            output logic ack, output bit valid, output bit err,
                            output logic [7:0] data);
      logic [9:0] bits;
      bit ok;
      int n;
      bits  = {stop, par, d};
      ack   = 1'b1;
      valid = 1'b0;
      err   = 1'b0;
      data  = 8'h00;
      host_clk_low = 1'b1;
      wait_cycles(8);
      host_dat_low = 1'b1;
      wait_cycles(4);
      host_clk_low = 1'b0;
      wait_cycles(4);
      if (do_load) load_byte(ld);
      else wait_cycles(1);
      wait_cycles(1);
      host_dat_low = ~bits[0];
      for (int k = 0; k < 10; k++) begin
         wait_fall(ok, n);
         check("rx_fall", {31'd0, ok}, 32'd1);
         if (!ok) begin
            host_dat_low = 1'b0;
            return;
         end
         host_dat_low = (k < 9) ? ~bits[k+1] : 1'b0;
      end
      wait_fall(ok, n);
      check("rx_ack_fall", {31'd0, ok}, 32'd1);
      ack = ps2data_w;
      for (int j = 0; j < 3 * HALF_T; j++) begin
         @(negedge clk);
         if (bus_if.rx_valid) begin
            valid = 1'b1;
            data  = bus_if.rx_data;
            break;
         end
         if (bus_if.rx_error) begin
            err = 1'b1;
            break;
         end
      end
   endtask

   // ---------------- directed tests ----------------
   initial begin
      bit         ok;
      int         n;
      int         bad;
      int         snap;
      logic       ack;
      bit         valid;
      bit         err;
      logic [7:0] data;

      bus_if.tx_data = 8'h00;
      bus_if.tx_load = 1'b0;
      wait_cycles(5);
      check("rst_busy",   {31'd0, bus_if.tx_busy},  32'd0);
      check("rst_done",   {31'd0, bus_if.tx_done},  32'd0);
      check("rst_valid",  {31'd0, bus_if.rx_valid}, 32'd0);
      check("rst_rxdata", {24'd0, bus_if.rx_data},  32'd0);
      check("rst_clk",    {31'd0, ps2clk_w},        32'd1);
      check("rst_dat",    {31'd0, ps2data_w},       32'd1);
      rst_n = 1'b1;
      wait_cycles(IDLE_T + 5);

      // Test 1: 0x1C on an idle bus.
      load_byte(8'h1C);
      check("t1_busy", {31'd0, bus_if.tx_busy}, 32'd1);
      check("t1_pre_start", {31'd0, ps2data_w}, 32'd1);
      wait_start(ok, n);
      check("t1_start_lat", n, 32'd1);
      recv_tx(11'b10000111000, n);
      check("t1_first_fall", n, HALF_T);
      wait_cycles(GAP_T + IDLE_T + 10);

      // Test 2: 0xAA aborted by the host in bit 4; a load while busy is dropped.
      snap = done_cnt;
      load_byte(8'hAA);
      load_byte(8'h55);
      for (int i = 0; i < 4; i++) begin
         wait_fall(ok, n);
         check("t2_fall", {31'd0, ok}, 32'd1);
      end
      wait_cycles(HALF_T + 3);
      host_clk_low = 1'b1;
      ok = 1'b0;
      for (int j = 0; j < 2 * HALF_T; j++) begin
         @(negedge clk);
         if (bus_if.tx_abort) begin
            ok = 1'b1;
            break;
         end
      end
      check("t2_abort", {31'd0, ok}, 32'd1);
      wait_cycles(2);
      check("t2_dat_z", {31'd0, ps2data_w}, 32'd1);
      check("t2_busy", {31'd0, bus_if.tx_busy}, 32'd0);
      host_clk_low = 1'b0;
      wait_cycles(2);
      check("t2_clk_z", {31'd0, ps2clk_w}, 32'd1);
      bad = 0;
      for (int j = 0; j < GAP_T + IDLE_T + 20; j++) begin
         @(negedge clk);
         if (ps2data_w !== 1'b1 || ps2clk_w !== 1'b1) bad++;
      end
      check("t2_no_restart", bad, 32'd0);
      check("t2_no_done", done_cnt, snap);
      check("t2_abort_cnt", abort_cnt, 32'd1);

      // Test 3: host sends 0xFF with good parity.
      host_send(8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, ack, valid, err, data);
      check("t3_ack", {31'd0, ack}, 32'd0);
      check("t3_valid", {31'd0, valid}, 32'd1);
      check("t3_err", {31'd0, err}, 32'd0);
      check("t3_data", {24'd0, data}, 32'hFF);
      wait_cycles(GAP_T + 10);

      // Test 4: host sends 0xED with bad parity.
      host_send(8'hED, 1'b0, 1'b1, 1'b0, 8'h00, ack, valid, err, data);
      check("t4_ack", {31'd0, ack}, 32'd0);
      check("t4_valid", {31'd0, valid}, 32'd0);
      check("t4_err", {31'd0, err}, 32'd1);
      check("t4_keep", {24'd0, bus_if.rx_data}, 32'hFF);
      wait_cycles(GAP_T + 10);

      // Test 5: load 0x5A just after RTS; RX first, then TX after gap and idle.
      host_send(8'h3C, 1'b1, 1'b1, 1'b1, 8'h5A, ack, valid, err, data);
      check("t5_valid", {31'd0, valid}, 32'd1);
      check("t5_data", {24'd0, data}, 32'h3C);
      check("t5_busy", {31'd0, bus_if.tx_busy}, 32'd1);
      wait_start(ok, n);
      check("t5_start", {31'd0, ok}, 32'd1);
      check("t5_gap", {31'd0, (n >= GAP_T + IDLE_T)}, 32'd1);
      recv_tx(11'b11010110100, n);
      wait_cycles(GAP_T + IDLE_T + 10);

      // Test 6: reset in bit 6 of a frame, then a clean 0x12.
      load_byte(8'h00);
      wait_start(ok, n);
      check("t6_start", {31'd0, ok}, 32'd1);
      for (int i = 0; i < 7; i++) begin
         wait_fall(ok, n);
         check("t6_fall", {31'd0, ok}, 32'd1);
      end
      check("t6_pre_clk", {31'd0, ps2clk_w}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("t6_clk_z", {31'd0, ps2clk_w}, 32'd1);
      check("t6_dat_z", {31'd0, ps2data_w}, 32'd1);
      check("t6_busy", {31'd0, bus_if.tx_busy}, 32'd0);
      check("t6_rxdata", {24'd0, bus_if.rx_data}, 32'd0);
      check("t6_pulses", {28'd0, bus_if.tx_done, bus_if.tx_abort,
                          bus_if.rx_valid, bus_if.rx_error}, 32'd0);
      wait_cycles(3);
      rst_n = 1'b1;
      wait_cycles(IDLE_T + 5);
      load_byte(8'h12);
      wait_start(ok, n);
      check("t6_restart", {31'd0, ok}, 32'd1);
      recv_tx(11'b11000100100, n);

      check("no_overlap", overlap_cnt, 32'd0);

      // ---------------- report ----------------
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
